cmd_rx_framer: RTL



---
 rtl/cmd_rx_framer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cmd_rx_framer.sv
// Frame buffer between the SPI byte receiver and cmd_in; stats counters under CMD_RX_FRAMER_STATS_EN.
// Latency: a frame is visible on cmd_out the cycle after its rx_frame_end edge.
// Backpressure: none toward rx (oversize frames are dropped whole); cmd_out holds data while !ready.
package cmd_rx_framer_pkg;
    typedef logic [7:0] byte_t;
endpackage

module cmd_rx_framer
    import cmd_rx_framer_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx_valid,
    input  byte_t            rx_data,
    input  logic             rx_frame_end,
    output logic             cmd_out_valid,
    input  logic             cmd_out_ready,
    output byte_t            cmd_out_data,
    output logic [PTR_W-1:0] level,
    output logic             overflow,
    output logic [15:0]      frames_ok,
    output logic [15:0]      frames_dropped
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] cm_q, cm_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    byte_t            mem_q [DEPTH];
    logic             mem_we;

    logic [PTR_W-1:0] used;
    logic [PTR_W-1:0] committed;
    logic             has_space;
    logic             rd_fire;

    assign used      = wr_q - rd_q;
    assign committed = cm_q - rd_q;
    // Space is judged before this cycle's read, so a concurrent pop never rescues a full buffer.
    assign has_space = (used != PTR_W'(DEPTH));

    assign cmd_out_valid = (committed != '0);
    assign cmd_out_data  = mem_q[rd_q[IDX_W-1:0]];
    assign rd_fire       = cmd_out_valid & cmd_out_ready;
    assign level         = level_q;
    assign overflow      = overflow_q;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        cm_d       = cm_q;
        mem_we     = 1'b0;
        overflow_d = 1'b0;
        rd_d       = rd_q + PTR_W'(rd_fire);

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (has_space) begin
                        mem_we = 1'b1;
                        wr_d   = wr_q + PTR_W'(1);
                        if (rx_frame_end) begin
                            cm_d = wr_q + PTR_W'(1);
                        end else begin
                            state_d = RECV;
                        end
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = rx_frame_end ? IDLE : DISCARD;
                    end
                end
            end
            RECV: begin
                if (rx_valid && !has_space) begin
                    wr_d       = cm_q;
                    overflow_d = 1'b1;
                    state_d    = rx_frame_end ? IDLE : DISCARD;
                end else begin
                    if (rx_valid) begin
                        mem_we = 1'b1;
                        wr_d   = wr_q + PTR_W'(1);
                    end
                    if (rx_frame_end) begin
                        cm_d    = wr_q + PTR_W'(rx_valid);
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (rx_frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        level_d = wr_d - rd_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            cm_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            cm_q       <= cm_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_q[IDX_W-1:0]] <= rx_data;
        end
    end

`ifdef CMD_RX_FRAMER_STATS_EN
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;
    logic        commit_evt;

    // An open frame never spans 2*DEPTH, so a commit always moves cm.
    assign commit_evt = (cm_d != cm_q);

    always_comb begin
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;
        if (commit_evt && (frames_ok_q != 16'hFFFF)) begin
            frames_ok_d = frames_ok_q + 16'd1;
        end
        if (overflow_d && (frames_dropped_q != 16'hFFFF)) begin
            frames_dropped_d = frames_dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
`else
    assign frames_ok      = '0;
    assign frames_dropped = '0;
`endif

endmodule
